// File: rtl/triangle_decoder.sv
// Triangle-wave stream monitor: locks onto a 0 -> 2^N-1 -> 0 sample sequence, flags turnarounds,
// measures trough-to-trough period and reports step errors. Optional: TRIANGLE_DECODER_ERR_COUNT_EN.
module triangle_decoder #(
  parameter int unsigned N        = 8,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [N-1:0]        in,
  output logic                locked,
  output logic                direction,
  output logic                peak,
  output logic                trough,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
`ifdef TRIANGLE_DECODER_ERR_COUNT_EN
  output logic                error,
  output logic [15:0]         err_count
`else
  output logic                error
`endif
);

  localparam int unsigned EC_W = 16;

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_UP      = 2'd2;
  localparam logic [1:0] S_DOWN    = 2'd3;

  localparam logic [N-1:0]        SMP_MAX  = {N{1'b1}};
  localparam logic [N-1:0]        SMP_ZERO = '0;
  localparam logic [N-1:0]        SMP_ONE  = N'(1);
  localparam logic [PERIOD_W-1:0] CNT_MAX  = {PERIOD_W{1'b1}};

  logic [1:0]          state_q, state_d;
  logic [N-1:0]        prev_q, prev_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                seen_q, seen_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                locked_q, locked_d;
  logic                dir_q, dir_d;
  logic                peak_q, peak_d;
  logic                trough_q, trough_d;
  logic                pv_q, pv_d;
  logic                error_q, error_d;

  logic [N-1:0]        prev_inc, prev_dec;
  logic [PERIOD_W-1:0] cnt_inc;
  logic [N-1:0]        exp_val;
  logic [1:0]          exp_state;

  assign prev_inc = prev_q + SMP_ONE;
  assign prev_dec = prev_q - SMP_ONE;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + PERIOD_W'(1);

  // Expected next sample and state while tracking; turnarounds reverse at the rails.
  always_comb begin
    exp_val   = prev_inc;
    exp_state = S_UP;
    if (state_q == S_UP) begin
      if (prev_q == SMP_MAX) begin
        exp_val   = prev_dec;
        exp_state = S_DOWN;
      end
    end else begin
      exp_val   = prev_dec;
      exp_state = S_DOWN;
      if (prev_q == SMP_ZERO) begin
        exp_val   = SMP_ONE;
        exp_state = S_UP;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    period_d = period_q;
    dir_d    = dir_q;
    peak_d   = 1'b0;
    trough_d = 1'b0;
    pv_d     = 1'b0;
    error_d  = 1'b0;
    if (ena) begin
      case (state_q)
        S_EMPTY: begin
          prev_d  = in;
          state_d = S_ACQUIRE;
        end
        S_ACQUIRE: begin
          prev_d = in;
          if ((prev_q != SMP_MAX) && (in == prev_inc)) begin
            state_d = S_UP;
          end else if ((prev_q != SMP_ZERO) && (in == prev_dec)) begin
            state_d = S_DOWN;
          end
        end
        default: begin
          prev_d = in;
          if (in == exp_val) begin
            state_d = exp_state;
            cnt_d   = cnt_inc;
            if ((state_q == S_UP) && (in == SMP_MAX)) begin
              peak_d = 1'b1;
            end
            // Trough closes a period; the first one after lock only arms the measurement.
            if ((state_q == S_DOWN) && (in == SMP_ZERO)) begin
              trough_d = 1'b1;
              cnt_d    = '0;
              seen_d   = 1'b1;
              if (seen_q) begin
                period_d = cnt_inc;
                pv_d     = 1'b1;
              end
            end
          end else begin
            error_d = 1'b1;
            state_d = S_ACQUIRE;
            cnt_d   = '0;
            seen_d  = 1'b0;
          end
        end
      endcase
    end
    locked_d = (state_d == S_UP) || (state_d == S_DOWN);
    if (state_d == S_UP) begin
      dir_d = 1'b1;
    end else if (state_d == S_DOWN) begin
      dir_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_EMPTY;
      prev_q   <= '0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      period_q <= '0;
      locked_q <= 1'b0;
      dir_q    <= 1'b1;
      peak_q   <= 1'b0;
      trough_q <= 1'b0;
      pv_q     <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      period_q <= period_d;
      locked_q <= locked_d;
      dir_q    <= dir_d;
      peak_q   <= peak_d;
      trough_q <= trough_d;
      pv_q     <= pv_d;
      error_q  <= error_d;
    end
  end

  assign locked       = locked_q;
  assign direction    = dir_q;
  assign peak         = peak_q;
  assign trough       = trough_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign error        = error_q;

`ifdef TRIANGLE_DECODER_ERR_COUNT_EN
  logic [EC_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating error tally, updated alongside the error pulse.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (error_d && (err_cnt_q != {EC_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + EC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_triangle_decoder.sv
// Scoreboard bench for triangle_decoder: a behavioural model predicts each cycle's outputs,
// which are queued on drive and compared once the DUT responds.
module tb_triangle_decoder;

  localparam int unsigned N    = 8;
  localparam int unsigned PW   = 16;
  localparam int          MAXV = 255;
  localparam int          PMAX = 65535;

  localparam int ST_EMPTY = 0;
  localparam int ST_ACQ   = 1;
  localparam int ST_UP    = 2;
  localparam int ST_DOWN  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic [N-1:0]  in_s;
  logic          locked, direction, peak, trough, period_valid, error;
  logic [PW-1:0] period;
  logic [15:0]   ec_obs;

  triangle_decoder #(.N(N), .PERIOD_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .in           (in_s),
    .locked       (locked),
    .direction    (direction),
    .peak         (peak),
    .trough       (trough),
    .period       (period),
    .period_valid (period_valid),
`ifdef TRIANGLE_DECODER_ERR_COUNT_EN
    .error        (error),
    .err_count    (ec_obs)
`else
    .error        (error)
`endif
  );

`ifndef TRIANGLE_DECODER_ERR_COUNT_EN
  assign ec_obs = 16'h0;
`endif

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  string scen = "init";

  int m_st, m_prev, m_cnt, m_seen, m_per, m_dir, m_ec;
  bit m_pk, m_tr, m_pv, m_er;
  int n_peak, n_trough, n_pv, n_err;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_out(input bit l, input bit d, input bit p, input bit t,
                                           input bit v, input bit e, input logic [15:0] per,
                                           input logic [15:0] ec);
    return {26'b0, ec, l, d, p, t, v, e, per};
  endfunction

  function automatic int tri_val(input int k);
    int m;
    m = k % 510;
    return (m <= MAXV) ? m : 510 - m;
  endfunction

  task automatic model_step(input bit r, input bit e, input int v);
    int expv, nst;
    m_pk = 0; m_tr = 0; m_pv = 0; m_er = 0;
    if (!r) begin
      m_st = ST_EMPTY; m_prev = 0; m_cnt = 0; m_seen = 0; m_per = 0; m_dir = 1; m_ec = 0;
    end else if (e) begin
      if (m_st == ST_EMPTY) begin
        m_prev = v; m_st = ST_ACQ;
      end else if (m_st == ST_ACQ) begin
        if (m_prev != MAXV && v == m_prev + 1) m_st = ST_UP;
        else if (m_prev != 0 && v == m_prev - 1) m_st = ST_DOWN;
        m_prev = v;
      end else begin
        if (m_st == ST_UP) begin
          expv = (m_prev == MAXV) ? MAXV - 1 : m_prev + 1;
          nst  = (m_prev == MAXV) ? ST_DOWN : ST_UP;
        end else begin
          expv = (m_prev == 0) ? 1 : m_prev - 1;
          nst  = (m_prev == 0) ? ST_UP : ST_DOWN;
        end
        if (v == expv) begin
          m_pk = (m_st == ST_UP) && (v == MAXV);
          m_tr = (m_st == ST_DOWN) && (v == 0);
          if (m_tr) begin
            if (m_seen != 0) begin
              m_per = (m_cnt < PMAX) ? m_cnt + 1 : PMAX;
              m_pv  = 1;
            end
            m_cnt = 0; m_seen = 1;
          end else begin
            m_cnt = (m_cnt < PMAX) ? m_cnt + 1 : PMAX;
          end
          m_st = nst;
        end else begin
          m_er = 1; m_st = ST_ACQ; m_cnt = 0; m_seen = 0;
          if (m_ec < 65535) m_ec++;
        end
        m_prev = v;
      end
      if (m_st == ST_UP) m_dir = 1;
      else if (m_st == ST_DOWN) m_dir = 0;
    end
  endtask

  task automatic cycle(input bit r, input bit e, input int v);
    logic [63:0] ex;
    logic [15:0] ec_m;
    @(negedge clk);
    rst = r; ena = e; in_s = N'(v);
    model_step(r, e, v);
`ifdef TRIANGLE_DECODER_ERR_COUNT_EN
    ec_m = 16'(m_ec);
`else
    ec_m = 16'h0;
`endif
    exp_q.push_back(pack_out((m_st == ST_UP) || (m_st == ST_DOWN), m_dir[0], m_pk, m_tr, m_pv,
                             m_er, 16'(m_per), ec_m));
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    check_eq(scen, pack_out(locked, direction, peak, trough, period_valid, error, period, ec_obs), ex);
    n_peak   += int'(peak);
    n_trough += int'(trough);
    n_pv     += int'(period_valid);
    n_err    += int'(error);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    n_peak = 0; n_trough = 0; n_pv = 0; n_err = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time budget exhausted");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; ena = 1'b0; in_s = '0;

    scen = "reset";
    do_reset();
    check_eq("rst_locked", 64'(locked), 64'd0);
    check_eq("rst_dir", 64'(direction), 64'd1);
    check_eq("rst_period", 64'(period), 64'd0);

    scen = "clean";
    for (int k = 0; k <= 1020; k++) begin
      cycle(1, 1, tri_val(k));
      if (k == 1) begin
        check_eq("clean_lock2", 64'({locked, direction}), 64'd3);
      end
    end
    check_eq("clean_peaks", 64'(n_peak), 64'd2);
    check_eq("clean_troughs", 64'(n_trough), 64'd2);
    check_eq("clean_pv", 64'(n_pv), 64'd1);
    check_eq("clean_period", 64'(period), 64'd510);
    check_eq("clean_err", 64'(n_err), 64'd0);

    scen = "toggle";
    do_reset();
    for (int k = 0; k <= 1020; k++) begin
      cycle(1, 1, tri_val(k));
      cycle(1, 0, tri_val(k + 7));
    end
    check_eq("tog_peaks", 64'(n_peak), 64'd2);
    check_eq("tog_pv", 64'(n_pv), 64'd1);
    check_eq("tog_period", 64'(period), 64'd510);
    check_eq("tog_err", 64'(n_err), 64'd0);

    scen = "inject";
    do_reset();
    cycle(1, 1, 98); cycle(1, 1, 99); cycle(1, 1, 100);
    cycle(1, 1, 103);
    check_eq("inj_err", 64'({error, locked}), 64'b10);
    cycle(1, 1, 104);
    check_eq("inj_relock", 64'({error, locked, direction}), 64'b011);
    n_pv = 0; n_trough = 0;
    for (int v = 105; v <= 255; v++) cycle(1, 1, v);
    for (int v = 254; v >= 0; v--) cycle(1, 1, v);
    check_eq("inj_trough1_pv", 64'({n_trough[7:0], n_pv[7:0]}), 64'h0100);
    for (int k = 1; k <= 510; k++) cycle(1, 1, tri_val(k));
    check_eq("inj_trough2_pv", 64'(n_pv), 64'd1);
    check_eq("inj_period", 64'(period), 64'd510);

    scen = "midwave";
    do_reset();
    cycle(1, 1, 250);
    cycle(1, 1, 251);
    check_eq("mid_lock", 64'(locked), 64'd1);
    for (int v = 252; v <= 255; v++) cycle(1, 1, v);
    cycle(1, 1, 254);
    check_eq("mid_peak", 64'(n_peak), 64'd1);
    check_eq("mid_flip", 64'({locked, direction, error}), 64'b100);
    check_eq("mid_err", 64'(n_err), 64'd0);

    scen = "rst_mid";
    do_reset();
    cycle(1, 1, 40); cycle(1, 1, 39); cycle(1, 1, 38); cycle(1, 1, 37);
    check_eq("rm_down", 64'({locked, direction}), 64'b10);
    cycle(0, 1, 36);
    check_eq("rm_reset", 64'({locked, direction, peak, trough, period_valid, error}), 64'b010000);
    cycle(1, 1, 36);
    check_eq("rm_acq", 64'(locked), 64'd0);
    cycle(1, 1, 35);
    check_eq("rm_relock", 64'({locked, direction}), 64'b10);

`ifdef TRIANGLE_DECODER_ERR_COUNT_EN
    scen = "errcnt";
    do_reset();
    cycle(1, 1, 10); cycle(1, 1, 11);
    cycle(1, 1, 50); cycle(1, 1, 51);
    cycle(1, 1, 60); cycle(1, 1, 61);
    cycle(1, 1, 70);
    check_eq("ec_three", 64'(ec_obs), 64'd3);
    cycle(0, 0, 0);
    check_eq("ec_clear", 64'(ec_obs), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/triangle_decoder.md
Name: triangle_decoder

Overview:
- Receive end of the triangle-wave sample stream: consumes N-bit samples qualified by `ena` and checks them against the 0 -> 2^N-1 -> 0 triangle sequence.
- Recovers direction, flags peaks and troughs, measures wave period in accepted samples, and reports sequence errors.
- Sits downstream of the triangle wave source in waveform/PWM test datapaths as a monitor and lock detector.

Parameters:
- N, 8, sample width; legal range N >= 2.
- PERIOD_W, 16, width of period measurement; must hold 2^(N+1)-2.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- ena  input  1  sample valid; `in` is consumed only in cycles where ena=1.
- in  input  N  incoming triangle sample.
- locked  output  1  high while tracking in UP or DOWN.
- direction  output  1  1 = counting up, 0 = counting down; meaningful only when locked.
- peak  output  1  one-cycle pulse: sample 2^N-1 accepted while in UP.
- trough  output  1  one-cycle pulse: sample 0 accepted while in DOWN.
- period  output  PERIOD_W  accepted-sample count between the last two troughs.
- period_valid  output  1  one-cycle pulse when `period` updates.
- error  output  1  one-cycle pulse on a step mismatch while locked.

Behaviour:
- Reset (rst=0 at posedge): state=EMPTY; prev=0; locked=0; direction=1; peak=trough=period_valid=error=0; period=0; sample counter cnt=0; seen_trough=0.
- All outputs are registered. Response appears the cycle after the accepted sample. With ena=0, state, prev, cnt and period hold, and every pulse output is 0.
- States:
  - EMPTY: no previous sample held. On ena: prev<=in, go to ACQUIRE.
  - ACQUIRE: on ena:
    - in==prev+1 (mod 2^N, no wrap accepted: prev != 2^N-1) -> UP.
    - in==prev-1 (prev != 0) -> DOWN.
    - Otherwise stay in ACQUIRE.
    - prev<=in in all cases. No error is raised in ACQUIRE.
  - UP: expected = prev+1, except when prev==2^N-1, where expected = prev-1 and the next state is DOWN.
  - DOWN: expected = prev-1, except when prev==0, where expected = 1 and the next state is UP.
- Turnaround sequence: the legal stream is ...,2^N-2, 2^N-1, 2^N-2,... and ...,1, 0, 1,...
  - Peak pulses when 2^N-1 is accepted in UP.
  - Trough pulses when 0 is accepted in DOWN.
- Mismatch in UP/DOWN (in != expected):
  - error=1.
  - State goes to ACQUIRE with prev<=in.
  - locked drops.
  - cnt<=0 and seen_trough<=0.
  - period holds its last value.
- Period measurement:
  - cnt increments on every accepted sample while in UP/DOWN and saturates at 2^PERIOD_W-1.
  - On a trough: if seen_trough=1, then period<=cnt+1 and period_valid=1.
  - On every trough: cnt<=0 and seen_trough<=1.
  - For a full wave, period = 2^(N+1)-2 (510 for N=8).
- locked = (state is UP or DOWN). direction=1 in UP, 0 in DOWN. direction holds its last value in ACQUIRE and EMPTY.
- Reset asserted mid-wave overrides everything in that cycle. Lock must be reacquired, which takes two accepted samples.

Optional Feature:
- Macro: TRIANGLE_DECODER_ERR_COUNT_EN.
- Defined:
  - Adds output port err_count [15:0]: count of error pulses.
  - Reset to 0 and saturates at 16'hFFFF.
  - Increments in the same cycle error is asserted.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then clean triangle, ena=1 every cycle, N=8, starting at 0:
  - locked=1 after the 2nd sample, direction=1.
  - peak pulses after 255 is sampled, trough pulses after 0.
  - The first trough gives no period_valid. The second trough gives period_valid=1 with period=510. error never asserted.
- Same stream with ena toggling 1/0 every cycle: identical sequence of outputs, stretched 2x. All pulses are one cycle wide. period=510.
- Locked in UP at 100, inject 103:
  - error=1 for one cycle, locked=0.
  - Next 104 relocks UP.
  - No period_valid until two further troughs have been seen.
- Start mid-wave at 250 going up:
  - Lock on 251.
  - 254, 255, 254 accepted with peak pulse and direction flip to 0, error=0.
- rst=0 asserted for one cycle while locked in DOWN at 37:
  - All outputs return to reset values next cycle.
  - Samples 36, 35 relock DOWN with locked=1 after 35.
- With TRIANGLE_DECODER_ERR_COUNT_EN defined: inject 3 mismatches -> err_count=3. Reset clears it to 0.
